i2s_receiver: RTL and testbench
===============================

Name: i2s_receiver

Overview:
Serial-to-parallel I2S receiver for the audio codec's ADC/line-in path, the receive end of the i2s_controller link. It takes bit_clk, frame_clk and serial data as plain inputs and samples them in the slow_clk domain. It frames left/right words per the I2S standard (MSB one bit_clk after the frame_clk edge, frame_clk low = left) and emits each stereo pair with a one-cycle valid strobe. It sits beside i2s_controller under apu, clocked by slow_clk.

Parameters:
SAMPLE_WIDTH, 16, bits captured per channel; bits beyond this in a slot are discarded.
MAX_SLOT_BITS, 32, longest legal slot in bit_clk periods; longer slots raise frame_err.
SYNC_STAGES, 2, flip-flop synchronizer depth on bit_clk, frame_clk and sdata_in.

Ports:
clk  input  1  slow_clk domain clock; must be at least 4x bit_clk.
reset  input  1  synchronous, active-high.
enable  input  1  receiver enabled when high.
bit_clk  input  1  I2S serial clock, asynchronous to clk.
frame_clk  input  1  I2S word select (LRCK): 0 = left, 1 = right.
sdata_in  input  1  I2S serial data, MSB first.
sample_left  output  SAMPLE_WIDTH  last complete left word.
sample_right  output  SAMPLE_WIDTH  last complete right word.
sample_valid  output  1  one-cycle pulse when a new left/right pair is presented.
frame_err  output  1  one-cycle pulse on a short or overlong slot.

Behaviour:
- Reset (synchronous, active-high, on the clk edge): sample_left = 0, sample_right = 0, sample_valid = 0, frame_err = 0, shift register = 0, bit counter = 0, synchronizers = 0, state = SYNC.
- Inputs pass through SYNC_STAGES flip-flops. A bit_clk rising edge ("bedge") is detected when the synchronized value is 1 and its one-cycle-delayed copy is 0.
- frame_clk and sdata_in are sampled only on bedge. lrck_last holds frame_clk as sampled at the previous bedge. A "transition" is a bedge where sampled frame_clk differs from lrck_last.
- Bit counter cnt counts bits received in the current slot. It saturates at MAX_SLOT_BITS+1. It is cleared to 0 at each transition; the MSB therefore arrives at the first bedge after a transition, with cnt = 0.
- On any non-transition bedge in LEFT or RIGHT: if cnt < SAMPLE_WIDTH, shift sdata into shreg (MSB first). Then increment cnt.
- On a transition bedge, slot completion runs in this order:
  - if cnt < SAMPLE_WIDTH, shift in this bedge's sdata as the slot's final bit;
  - form the word from shreg, left-justified with zero-filled LSBs if fewer than SAMPLE_WIDTH bits arrived;
  - if the bits received (counting this bit) are fewer than SAMPLE_WIDTH, or cnt > MAX_SLOT_BITS, pulse frame_err.
- FSM states: SYNC, LEFT, RIGHT.
  - SYNC: wait for a transition with new frame_clk = 0, then go to LEFT. Nothing is latched.
  - LEFT: on a 0->1 transition, complete the slot into the held left word and go to RIGHT.
  - RIGHT: on a 1->0 transition, complete the slot. Update sample_left from the held word and sample_right from the completed word, pulse sample_valid, and go to LEFT.
- Latency: a pin-level bit_clk rise is reflected in the outputs SYNC_STAGES+2 clk edges later. sample_valid and frame_err are high for exactly one clk cycle.
- Outputs hold their values between pairs.
- If a 1->0 transition and an error coincide, sample_valid and frame_err pulse in the same cycle and the pair is still delivered.
- enable low: state forced to SYNC, cnt cleared, sample_valid = 0, data outputs hold. Re-enabling resynchronizes on the next 1->0 transition.
- Reset mid-frame: immediate return to reset values. The partially received word is discarded.

Decomposition:
- Shared package/header i2s_defs: state encodings (SYNC/LEFT/RIGHT) and default SAMPLE_WIDTH, shared with i2s_controller.
- Sub-module i2s_rx_sync: SYNC_STAGES synchronizers for the three inputs plus the bedge detector. Outputs are synchronized frame_clk, synchronized sdata and the bedge pulse.

Test Plan:
- Reset: hold reset 3 cycles with random pins -> all outputs 0; no valid for 10 cycles after release while frame_clk is idle.
- Nominal 64fs: bit_clk = clk/4, 32-bit slots, left 16'hA5C3, right 16'h1234 -> one sample_valid with sample_left = A5C3 and sample_right = 1234, SYNC_STAGES+2 clk edges after the bit_clk rise that samples frame_clk 1->0; frame_err never pulses.
- Exact 16-bit slots (32fs): stream L/R pairs 8001/7FFE, then FFFF/0000 -> two valids with matching values, confirming the final-bit-on-transition path.
- Mid-frame start: enable asserted halfway through a left slot -> the first valid arrives only after a complete L then R slot, and the partial word is never output.
- Short slot: 12-bit slots, left 12'hABC, right 12'h123 -> sample_left = ABC0, sample_right = 1230, frame_err pulse on both transitions; an overlong slot of 40 bits -> frame_err pulse.
- Disruption: reset asserted mid-right-slot (outputs cleared), then enable dropped for one frame (no valid, outputs held) -> clean resync and correct data on the following frame.

Source files
------------

// File: rtl/i2s_receiver_pkg.sv
// Shared I2S receive definitions: framing state encodings and default word width.
package i2s_receiver_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

  localparam int DEFAULT_SAMPLE_WIDTH = 16;

endpackage

// File: rtl/i2s_receiver_if.sv
// Pin-side and sample-side signals of the I2S receiver, bundled for the top-level port.
interface i2s_receiver_if
  import i2s_receiver_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH
);
  logic                    enable;
  logic                    bit_clk;
  logic                    frame_clk;
  logic                    sdata_in;
  logic [SAMPLE_WIDTH-1:0] sample_left;
  logic [SAMPLE_WIDTH-1:0] sample_right;
  logic                    sample_valid;
  logic                    frame_err;

  modport master (
    output enable, bit_clk, frame_clk, sdata_in,
    input  sample_left, sample_right, sample_valid, frame_err
  );

  modport slave (
    input  enable, bit_clk, frame_clk, sdata_in,
    output sample_left, sample_right, sample_valid, frame_err
  );
endinterface

// File: rtl/i2s_receiver_rx_sync.sv
// Synchronizes bit_clk, frame_clk and sdata into clk_i and flags bit_clk rising edges.
// All three outputs are registered together so frame/data line up with the bedge pulse.
module i2s_receiver_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic bit_clk_i,
  input  logic frame_clk_i,
  input  logic sdata_i,
  output logic bedge_o,
  output logic frame_o,
  output logic sdata_o
);
  logic [SYNC_STAGES-1:0] bclk_q, frame_q, sdata_q;
  logic bclk_prev_q, bedge_q, frame_out_q, sdata_out_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bclk_q      <= '0;
      frame_q     <= '0;
      sdata_q     <= '0;
      bclk_prev_q <= 1'b0;
      bedge_q     <= 1'b0;
      frame_out_q <= 1'b0;
      sdata_out_q <= 1'b0;
    end else begin
      bclk_q      <= SYNC_STAGES'({bclk_q, bit_clk_i});
      frame_q     <= SYNC_STAGES'({frame_q, frame_clk_i});
      sdata_q     <= SYNC_STAGES'({sdata_q, sdata_i});
      bclk_prev_q <= bclk_q[SYNC_STAGES-1];
      bedge_q     <= bclk_q[SYNC_STAGES-1] & ~bclk_prev_q;
      frame_out_q <= frame_q[SYNC_STAGES-1];
      sdata_out_q <= sdata_q[SYNC_STAGES-1];
    end
  end

  assign bedge_o = bedge_q;
  assign frame_o = frame_out_q;
  assign sdata_o = sdata_out_q;
endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: frames left/right slots from the synchronized serial stream.
//   state | meaning
//   SYNC  | waiting for a 1->0 frame_clk transition; nothing latched
//   LEFT  | collecting the left slot
//   RIGHT | collecting the right slot; pair delivered at its end
module i2s_receiver
  import i2s_receiver_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = DEFAULT_SAMPLE_WIDTH,
  parameter int MAX_SLOT_BITS = 32,
  parameter int SYNC_STAGES   = 2
) (
  input logic           clk_i,
  input logic           reset_i,
  i2s_receiver_if.slave rx
);
  localparam int CNT_W = $clog2(MAX_SLOT_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_SLOT_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SLOT_BITS);
  localparam logic [CNT_W-1:0] CNT_SW  = CNT_W'(SAMPLE_WIDTH);

  logic bedge, frame_s, sdata_s;

  i2s_receiver_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .bit_clk_i   (rx.bit_clk),
    .frame_clk_i (rx.frame_clk),
    .sdata_i     (rx.sdata_in),
    .bedge_o     (bedge),
    .frame_o     (frame_s),
    .sdata_o     (sdata_s)
  );

  i2s_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d, held_q, held_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                    lrck_q, lrck_d, valid_q, valid_d, err_q, err_d;

  logic                    transition, take_bit, short_slot;
  logic [CNT_W-1:0]        nbits;
  logic [SAMPLE_WIDTH-1:0] shifted, word;

  assign transition = bedge && (frame_s != lrck_q);
  assign take_bit   = cnt_q < CNT_SW;
  assign shifted    = take_bit ? {shreg_q[SAMPLE_WIDTH-2:0], sdata_s} : shreg_q;
  assign nbits      = take_bit ? cnt_q + 1'b1 : CNT_SW;
  assign short_slot = nbits < CNT_SW;
  // Short slots are left-justified so the received bits keep their MSB weighting.
  assign word       = shifted << (CNT_SW - nbits);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    held_d  = held_q;
    left_d  = left_q;
    right_d = right_q;
    lrck_d  = bedge ? frame_s : lrck_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (!rx.enable) begin
      state_d = SYNC;
      cnt_d   = '0;
      shreg_d = '0;
    end else if (bedge) begin
      case (state_q)
        SYNC: begin
          if (transition && !frame_s) begin
            state_d = LEFT;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end
        LEFT, RIGHT: begin
          if (transition) begin
            cnt_d   = '0;
            shreg_d = '0;
            err_d   = short_slot || (cnt_q > CNT_MAX);
            if (state_q == LEFT) begin
              held_d  = word;
              state_d = RIGHT;
            end else begin
              left_d  = held_q;
              right_d = word;
              valid_d = 1'b1;
              state_d = LEFT;
            end
          end else begin
            shreg_d = shifted;
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      shreg_q <= '0;
      held_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      lrck_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      held_q  <= held_d;
      left_q  <= left_d;
      right_q <= right_d;
      lrck_q  <= lrck_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign rx.sample_left  = left_q;
  assign rx.sample_right = right_q;
  assign rx.sample_valid = valid_q;
  assign rx.frame_err    = err_q;
endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: bit_clk = clk/4, data lags frame_clk by one bit.
module tb_i2s_receiver;
  logic clk;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  i2s_receiver_if #(.SAMPLE_WIDTH(16)) rx();

  i2s_receiver #(.SAMPLE_WIDTH(16), .MAX_SLOT_BITS(32), .SYNC_STAGES(2)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .rx      (rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: single writer of the pulse counters and captured pairs.
  int          valid_cnt = 0;
  int          err_cnt = 0;
  int          valid_cyc = 0;
  int          err_cyc = 0;
  logic [15:0] vl_q[$];
  logic [15:0] vr_q[$];

  always @(negedge clk) begin
    if (rx.sample_valid === 1'b1) begin
      valid_cnt++;
      valid_cyc = cyc;
      vl_q.push_back(rx.sample_left);
      vr_q.push_back(rx.sample_right);
    end
    if (rx.frame_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  // Stimulus stream: per bit_clk period a frame value, a data bit and an enable value.
  logic fq[$];
  logic dq[$];
  logic eq[$];
  int   rise_cyc[$];
  logic last_d = 1'b0;

  task automatic add_slot(input logic fr, input logic [31:0] w, input int wbits,
                          input int len, input logic en);
    for (int i = 0; i < len; i++) begin
      fq.push_back(fr);
      dq.push_back((i < wbits) ? w[wbits-1-i] : 1'b0);
      eq.push_back(en);
    end
  endtask

  task automatic play();
    rise_cyc.delete();
    for (int k = 0; k < fq.size(); k++) begin
      rx.enable    = eq[k];
      rx.bit_clk   = 1'b0;
      rx.frame_clk = fq[k];
      rx.sdata_in  = last_d;
      repeat (2) @(posedge clk);
      #2;
      rx.bit_clk = 1'b1;
      rise_cyc.push_back(cyc);
      repeat (2) @(posedge clk);
      #2;
      last_d = dq[k];
    end
    fq.delete();
    dq.delete();
    eq.delete();
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic apply_reset(input bit rnd);
    reset = 1'b1;
    repeat (3) begin
      if (rnd) begin
        rx.bit_clk   = 1'($urandom);
        rx.frame_clk = 1'($urandom);
        rx.sdata_in  = 1'($urandom);
        rx.enable    = 1'($urandom);
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic release_reset();
    rx.bit_clk   = 1'b0;
    rx.frame_clk = 1'b0;
    rx.sdata_in  = 1'b0;
    last_d       = 1'b0;
    reset        = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    int v0, e0;
    apply_reset(1'b1);
    checks++; if (rx.sample_left !== 16'h0) $display("FAIL reset_left: got %h expected 0000", rx.sample_left); else passed++;
    checks++; if (rx.sample_right !== 16'h0) $display("FAIL reset_right: got %h expected 0000", rx.sample_right); else passed++;
    checks++; if (rx.sample_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rx.sample_valid); else passed++;
    checks++; if (rx.frame_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", rx.frame_err); else passed++;
    rx.enable = 1'b1;
    release_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    repeat (10) @(posedge clk);
    #2;
    checks++; if (valid_cnt - v0 !== 0) $display("FAIL reset_idle_valid: got %0d pulses expected 0", valid_cnt - v0); else passed++;
    checks++; if (err_cnt - e0 !== 0) $display("FAIL reset_idle_err: got %0d pulses expected 0", err_cnt - e0); else passed++;
  endtask

  task automatic test_nominal();
    int v0, e0;
    apply_reset(1'b0);
    release_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    add_slot(1'b1, 32'h0, 0, 32, 1'b1);
    add_slot(1'b0, 32'hA5C3, 16, 32, 1'b1);
    add_slot(1'b1, 32'h1234, 16, 32, 1'b1);
    add_slot(1'b0, 32'h0, 0, 4, 1'b1);
    play();
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL nominal_valid_count: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (rx.sample_left !== 16'hA5C3) $display("FAIL nominal_left: got %h expected a5c3", rx.sample_left); else passed++;
    checks++; if (rx.sample_right !== 16'h1234) $display("FAIL nominal_right: got %h expected 1234", rx.sample_right); else passed++;
    checks++; if (valid_cyc - rise_cyc[96] !== 4) $display("FAIL nominal_latency: got %0d edges expected 4", valid_cyc - rise_cyc[96]); else passed++;
    checks++; if (err_cnt - e0 !== 0) $display("FAIL nominal_err: got %0d pulses expected 0", err_cnt - e0); else passed++;
  endtask

  task automatic test_32fs();
    int v0, e0;
    apply_reset(1'b0);
    release_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    add_slot(1'b1, 32'h0, 0, 16, 1'b1);
    add_slot(1'b0, 32'h8001, 16, 16, 1'b1);
    add_slot(1'b1, 32'h7FFE, 16, 16, 1'b1);
    add_slot(1'b0, 32'hFFFF, 16, 16, 1'b1);
    add_slot(1'b1, 32'h0000, 16, 16, 1'b1);
    add_slot(1'b0, 32'h0, 0, 2, 1'b1);
    play();
    checks++; if (valid_cnt - v0 !== 2) $display("FAIL fs32_valid_count: got %0d expected 2", valid_cnt - v0); else passed++;
    checks++; if (vl_q[v0] !== 16'h8001) $display("FAIL fs32_left0: got %h expected 8001", vl_q[v0]); else passed++;
    checks++; if (vr_q[v0] !== 16'h7FFE) $display("FAIL fs32_right0: got %h expected 7ffe", vr_q[v0]); else passed++;
    checks++; if (vl_q[v0+1] !== 16'hFFFF) $display("FAIL fs32_left1: got %h expected ffff", vl_q[v0+1]); else passed++;
    checks++; if (rx.sample_right !== 16'h0000) $display("FAIL fs32_right1: got %h expected 0000", rx.sample_right); else passed++;
    checks++; if (err_cnt - e0 !== 0) $display("FAIL fs32_err: got %0d pulses expected 0", err_cnt - e0); else passed++;
  endtask

  task automatic test_midframe();
    int v0, e0;
    apply_reset(1'b0);
    rx.enable = 1'b0;
    release_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    add_slot(1'b0, 32'hDEAD, 16, 16, 1'b0);
    add_slot(1'b0, 32'h0, 0, 16, 1'b1);
    add_slot(1'b1, 32'hBEEF, 16, 32, 1'b1);
    add_slot(1'b0, 32'h1111, 16, 32, 1'b1);
    add_slot(1'b1, 32'h2222, 16, 32, 1'b1);
    add_slot(1'b0, 32'h0, 0, 2, 1'b1);
    play();
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL midframe_valid_count: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (rx.sample_left !== 16'h1111) $display("FAIL midframe_left: got %h expected 1111", rx.sample_left); else passed++;
    checks++; if (rx.sample_right !== 16'h2222) $display("FAIL midframe_right: got %h expected 2222", rx.sample_right); else passed++;
    checks++; if (err_cnt - e0 !== 0) $display("FAIL midframe_err: got %0d pulses expected 0", err_cnt - e0); else passed++;
  endtask

  task automatic test_short_long();
    int v0, e0;
    apply_reset(1'b0);
    rx.enable = 1'b1;
    release_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    add_slot(1'b1, 32'h0, 0, 12, 1'b1);
    add_slot(1'b0, 32'hABC, 12, 12, 1'b1);
    add_slot(1'b1, 32'h123, 12, 12, 1'b1);
    add_slot(1'b0, 32'h0, 0, 2, 1'b1);
    play();
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL short_valid_count: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (rx.sample_left !== 16'hABC0) $display("FAIL short_left: got %h expected abc0", rx.sample_left); else passed++;
    checks++; if (rx.sample_right !== 16'h1230) $display("FAIL short_right: got %h expected 1230", rx.sample_right); else passed++;
    checks++; if (err_cnt - e0 !== 2) $display("FAIL short_err_count: got %0d expected 2", err_cnt - e0); else passed++;
    checks++; if (err_cyc !== valid_cyc) $display("FAIL short_err_with_valid: err cycle %0d valid cycle %0d", err_cyc, valid_cyc); else passed++;

    apply_reset(1'b0);
    rx.enable = 1'b1;
    release_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    add_slot(1'b1, 32'h0, 0, 32, 1'b1);
    add_slot(1'b0, 32'h5555, 16, 40, 1'b1);
    add_slot(1'b1, 32'hAAAA, 16, 32, 1'b1);
    add_slot(1'b0, 32'h0, 0, 2, 1'b1);
    play();
    checks++; if (err_cnt - e0 !== 1) $display("FAIL long_err_count: got %0d expected 1", err_cnt - e0); else passed++;
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL long_valid_count: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (rx.sample_left !== 16'h5555) $display("FAIL long_left: got %h expected 5555", rx.sample_left); else passed++;
    checks++; if (rx.sample_right !== 16'hAAAA) $display("FAIL long_right: got %h expected aaaa", rx.sample_right); else passed++;
  endtask

  task automatic test_disruption();
    int v0, e0;
    apply_reset(1'b0);
    rx.enable = 1'b1;
    release_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    add_slot(1'b1, 32'h0, 0, 32, 1'b1);
    add_slot(1'b0, 32'h1357, 16, 32, 1'b1);
    add_slot(1'b1, 32'h2468, 16, 32, 1'b1);
    add_slot(1'b0, 32'h9999, 16, 32, 1'b1);
    add_slot(1'b1, 32'hFFFF, 16, 16, 1'b1);
    play();
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL disrupt_pre_count: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (rx.sample_left !== 16'h1357) $display("FAIL disrupt_pre_left: got %h expected 1357", rx.sample_left); else passed++;
    checks++; if (rx.sample_right !== 16'h2468) $display("FAIL disrupt_pre_right: got %h expected 2468", rx.sample_right); else passed++;

    apply_reset(1'b0);
    release_reset();
    repeat (6) @(posedge clk);
    #2;
    checks++; if (rx.sample_left !== 16'h0) $display("FAIL disrupt_rst_left: got %h expected 0000", rx.sample_left); else passed++;
    checks++; if (rx.sample_right !== 16'h0) $display("FAIL disrupt_rst_right: got %h expected 0000", rx.sample_right); else passed++;
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL disrupt_rst_count: got %0d expected 1", valid_cnt - v0); else passed++;

    v0 = valid_cnt;
    add_slot(1'b1, 32'h0, 0, 32, 1'b1);
    add_slot(1'b0, 32'hCAFE, 16, 32, 1'b1);
    add_slot(1'b1, 32'hF00D, 16, 32, 1'b1);
    add_slot(1'b0, 32'h0, 0, 4, 1'b1);
    play();
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL disrupt_b1_count: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (rx.sample_left !== 16'hCAFE) $display("FAIL disrupt_b1_left: got %h expected cafe", rx.sample_left); else passed++;
    checks++; if (rx.sample_right !== 16'hF00D) $display("FAIL disrupt_b1_right: got %h expected f00d", rx.sample_right); else passed++;

    add_slot(1'b0, 32'h0, 0, 28, 1'b0);
    add_slot(1'b1, 32'h2222, 16, 32, 1'b0);
    play();
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL disrupt_off_count: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (rx.sample_left !== 16'hCAFE) $display("FAIL disrupt_off_left: got %h expected cafe", rx.sample_left); else passed++;
    checks++; if (rx.sample_right !== 16'hF00D) $display("FAIL disrupt_off_right: got %h expected f00d", rx.sample_right); else passed++;

    add_slot(1'b0, 32'h3333, 16, 32, 1'b1);
    add_slot(1'b1, 32'h4444, 16, 32, 1'b1);
    add_slot(1'b0, 32'h0, 0, 2, 1'b1);
    play();
    checks++; if (valid_cnt - v0 !== 2) $display("FAIL disrupt_b3_count: got %0d expected 2", valid_cnt - v0); else passed++;
    checks++; if (rx.sample_left !== 16'h3333) $display("FAIL disrupt_b3_left: got %h expected 3333", rx.sample_left); else passed++;
    checks++; if (rx.sample_right !== 16'h4444) $display("FAIL disrupt_b3_right: got %h expected 4444", rx.sample_right); else passed++;
    checks++; if (err_cnt - e0 !== 0) $display("FAIL disrupt_err: got %0d pulses expected 0", err_cnt - e0); else passed++;
  endtask

  initial begin
    reset        = 1'b1;
    rx.enable    = 1'b0;
    rx.bit_clk   = 1'b0;
    rx.frame_clk = 1'b0;
    rx.sdata_in  = 1'b0;
    @(posedge clk);
    #2;
    test_reset();
    test_nominal();
    test_32fs();
    test_midframe();
    test_short_long();
    test_disruption();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
